// File: rtl/match_sched_if.sv
// Request / result / best-record channels between the match sweep controller
// and the ROM + VecMatch datapath.
interface match_sched_if #(
    parameter int OBS_AW = 6,
    parameter int NAV_AW = 14,
    parameter int CNT_W  = 11
);
    logic              req_valid;
    logic              req_ready;
    logic [OBS_AW-1:0] req_obs_addr;
    logic [NAV_AW-1:0] req_nav_addr;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count;
    logic              best_valid;
    logic              best_ready;
    logic [OBS_AW-1:0] best_obs;
    logic [NAV_AW-1:0] best_nav;
    logic [CNT_W-1:0]  best_count;
    logic              best_hit;

    modport master (
        output req_valid, req_obs_addr, req_nav_addr, res_ready,
               best_valid, best_obs, best_nav, best_count, best_hit,
        input  req_ready, res_valid, res_count, best_ready
    );

    modport slave (
        input  req_valid, req_obs_addr, req_nav_addr, res_ready,
               best_valid, best_obs, best_nav, best_count, best_hit,
        output req_ready, res_valid, res_count, best_ready
    );
endinterface

// File: rtl/match_sched.sv
// Sequences one obs x nav match sweep: issues address pairs under a credit
// limit, folds in-order results into a per-obs argmax and emits one record per obs.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing (obs, nav) pairs, consuming results
// DRAIN  | all pairs issued, waiting for results and record hand-off
// DONE   | one-cycle done pulse
module match_sched #(
    parameter int OBS_VEC_NUM = 49,
    parameter int NAV_VEC_NUM = 539,
    parameter int OBS_AW      = 6,
    parameter int NAV_AW      = 14,
    parameter int CNT_W       = 11,
    parameter int MAX_OUT     = 4,
    parameter int MIN_MATCH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    match_sched_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int OUT_W = 4;
    localparam logic [OBS_AW-1:0] OBS_LAST = OBS_AW'(OBS_VEC_NUM - 1);
    localparam logic [NAV_AW-1:0] NAV_LAST = NAV_AW'(NAV_VEC_NUM - 1);
    localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0]  HIT_MIN  = CNT_W'(MIN_MATCH);

    logic [1:0]        state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [OBS_AW-1:0] iobs_q, iobs_d;
    logic [NAV_AW-1:0] inav_q, inav_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic [OBS_AW-1:0] robs_q, robs_d;
    logic [NAV_AW-1:0] rnav_q, rnav_d;
    logic [CNT_W-1:0]  cur_max_q, cur_max_d;
    logic [NAV_AW-1:0] cur_arg_q, cur_arg_d;
    logic              best_valid_q, best_valid_d;
    logic [OBS_AW-1:0] best_obs_q, best_obs_d;
    logic [NAV_AW-1:0] best_nav_q, best_nav_d;
    logic [CNT_W-1:0]  best_count_q, best_count_d;
    logic              best_hit_q, best_hit_d;

    logic              active;
    logic              issue_hs;
    logic              res_hs;
    logic              res_ready_c;
    logic              final_res;
    logic              last_pair;
    logic [CNT_W-1:0]  new_max;
    logic [NAV_AW-1:0] new_arg;

    always_comb begin
        active      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        issue_hs    = req_valid_q && bus.req_ready;
        final_res   = (rnav_q == NAV_LAST);
        last_pair   = (iobs_q == OBS_LAST) && (inav_q == NAV_LAST);
        // A final result needs the record slot; it may only enter when the
        // slot is empty or being drained this same cycle.
        res_ready_c = active && (outstanding_q != '0) &&
                      !(best_valid_q && !bus.best_ready && final_res);
        res_hs      = bus.res_valid && res_ready_c;

        if (rnav_q == '0) begin
            new_max = bus.res_count;
            new_arg = '0;
        end else if (bus.res_count > cur_max_q) begin
            new_max = bus.res_count;
            new_arg = rnav_q;
        end else begin
            new_max = cur_max_q;
            new_arg = cur_arg_q;
        end

        state_d       = state_q;
        iobs_d        = iobs_q;
        inav_d        = inav_q;
        outstanding_d = outstanding_q;
        robs_d        = robs_q;
        rnav_d        = rnav_q;
        cur_max_d     = cur_max_q;
        cur_arg_d     = cur_arg_q;
        best_valid_d  = best_valid_q;
        best_obs_d    = best_obs_q;
        best_nav_d    = best_nav_q;
        best_count_d  = best_count_q;
        best_hit_d    = best_hit_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    iobs_d  = '0;
                    inav_d  = '0;
                    robs_d  = '0;
                    rnav_d  = '0;
                end
            end
            S_ISSUE: begin
                if (issue_hs && last_pair) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding_q == '0 && !best_valid_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue_hs) begin
            if (inav_q == NAV_LAST) begin
                inav_d = '0;
                iobs_d = iobs_q + 1'b1;
            end else begin
                inav_d = inav_q + 1'b1;
            end
        end

        case ({issue_hs, res_hs})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (best_valid_q && bus.best_ready) best_valid_d = 1'b0;

        if (res_hs) begin
            cur_max_d = new_max;
            cur_arg_d = new_arg;
            if (final_res) begin
                rnav_d       = '0;
                robs_d       = robs_q + 1'b1;
                best_valid_d = 1'b1;
                best_obs_d   = robs_q;
                best_nav_d   = new_arg;
                best_count_d = new_max;
                best_hit_d   = (new_max >= HIT_MIN);
            end else begin
                rnav_d = rnav_q + 1'b1;
            end
        end

        req_valid_d = (state_d == S_ISSUE) && (outstanding_d < OUT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_valid_q   <= 1'b0;
            iobs_q        <= '0;
            inav_q        <= '0;
            outstanding_q <= '0;
            robs_q        <= '0;
            rnav_q        <= '0;
            cur_max_q     <= '0;
            cur_arg_q     <= '0;
            best_valid_q  <= 1'b0;
            best_obs_q    <= '0;
            best_nav_q    <= '0;
            best_count_q  <= '0;
            best_hit_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            iobs_q        <= iobs_d;
            inav_q        <= inav_d;
            outstanding_q <= outstanding_d;
            robs_q        <= robs_d;
            rnav_q        <= rnav_d;
            cur_max_q     <= cur_max_d;
            cur_arg_q     <= cur_arg_d;
            best_valid_q  <= best_valid_d;
            best_obs_q    <= best_obs_d;
            best_nav_q    <= best_nav_d;
            best_count_q  <= best_count_d;
            best_hit_q    <= best_hit_d;
        end
    end

    assign busy             = active;
    assign done             = (state_q == S_DONE);
    assign bus.req_valid    = req_valid_q;
    assign bus.req_obs_addr = iobs_q;
    assign bus.req_nav_addr = inav_q;
    assign bus.res_ready    = res_ready_c;
    assign bus.best_valid   = best_valid_q;
    assign bus.best_obs     = best_obs_q;
    assign bus.best_nav     = best_nav_q;
    assign bus.best_count   = best_count_q;
    assign bus.best_hit     = best_hit_q;

endmodule

// File: tb/tb_match_sched.sv
// Directed bench for match_sched on a 2 x 3 sweep with a queue-based
// in-order datapath model answering each issued pair.
module tb_match_sched;

    localparam int OBS = 2;
    localparam int NAV = 3;
    localparam int OBS_AW = 6;
    localparam int NAV_AW = 14;
    localparam int CNT_W = 11;
    localparam int MAX_OUT = 4;
    localparam int MIN_MATCH = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    match_sched_if #(.OBS_AW(OBS_AW), .NAV_AW(NAV_AW), .CNT_W(CNT_W)) bus ();

    match_sched #(
        .OBS_VEC_NUM(OBS), .NAV_VEC_NUM(NAV), .OBS_AW(OBS_AW), .NAV_AW(NAV_AW),
        .CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .MIN_MATCH(MIN_MATCH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mode;
    bit rr_en, res_en, br_en;
    int q_obs[$];
    int q_nav[$];
    int rec_obs[$];
    int rec_nav[$];
    int rec_cnt[$];
    int rec_hit[$];
    int issued;
    int exp_obs, exp_nav;
    int done_cnt;
    int recs_at_done;
    bit stall_seen;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int cnt_of(input int o, input int n);
        int t0 [3] = '{5, 9, 9};
        int t1 [3] = '{2, 1, 12};
        if (mode == 1) return 3;
        return (o == 0) ? t0[n] : t1[n];
    endfunction

    // One clock: drive inputs at negedge, sample #1 later, handshake at next posedge.
    task automatic cycle();
        @(negedge clk);
        bus.req_ready  = rr_en;
        bus.best_ready = br_en;
        if (res_en && q_obs.size() > 0) begin
            bus.res_valid = 1'b1;
            bus.res_count = CNT_W'(cnt_of(q_obs[0], q_nav[0]));
        end else begin
            bus.res_valid = 1'b0;
            bus.res_count = '0;
        end
        #1;
        if (bus.res_valid && !bus.res_ready && bus.best_valid &&
            q_obs[0] == 1 && q_nav[0] == NAV - 1)
            stall_seen = 1'b1;
        if (bus.res_valid && bus.res_ready) begin
            void'(q_obs.pop_front());
            void'(q_nav.pop_front());
        end
        if (bus.req_valid && bus.req_ready) begin
            chk("pair_obs", 32'(bus.req_obs_addr), 32'(exp_obs));
            chk("pair_nav", 32'(bus.req_nav_addr), 32'(exp_nav));
            q_obs.push_back(int'(bus.req_obs_addr));
            q_nav.push_back(int'(bus.req_nav_addr));
            issued++;
            if (exp_nav == NAV - 1) begin
                exp_nav = 0;
                exp_obs++;
            end else begin
                exp_nav++;
            end
        end
        if (bus.best_valid && bus.best_ready) begin
            rec_obs.push_back(int'(bus.best_obs));
            rec_nav.push_back(int'(bus.best_nav));
            rec_cnt.push_back(int'(bus.best_count));
            rec_hit.push_back(int'(bus.best_hit));
        end
        if (done) begin
            done_cnt++;
            recs_at_done = rec_obs.size();
        end
    endtask

    task automatic start_sweep();
        q_obs.delete(); q_nav.delete();
        rec_obs.delete(); rec_nav.delete(); rec_cnt.delete(); rec_hit.delete();
        issued = 0; exp_obs = 0; exp_nav = 0; done_cnt = 0; recs_at_done = -1;
        stall_seen = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_req_valid", 32'(bus.req_valid), 32'd1);
    endtask

    task automatic finish_sweep(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            cycle();
            n++;
        end
        chk("done_seen", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 4; i++) cycle();
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("recs_before_done", 32'(recs_at_done), 32'(OBS));
        chk("pairs_issued", 32'(issued), 32'(OBS * NAV));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_rec(input int i, input int o, input int n, input int c, input int h);
        chk("rec_present", 32'(rec_obs.size() > i), 32'd1);
        if (rec_obs.size() > i) begin
            chk("rec_obs", 32'(rec_obs[i]), 32'(o));
            chk("rec_nav", 32'(rec_nav[i]), 32'(n));
            chk("rec_count", 32'(rec_cnt[i]), 32'(c));
            chk("rec_hit", 32'(rec_hit[i]), 32'(h));
        end
    endtask

    task automatic check_mode0_recs();
        check_rec(0, 0, 1, 9, 1);
        check_rec(1, 1, 2, 12, 1);
    endtask

    initial begin
        int n;
        int hold_obs, hold_nav;
        rst = 1'b1; start = 1'b0; mode = 0;
        rr_en = 1'b1; res_en = 1'b1; br_en = 1'b1;
        bus.req_ready = 1'b0; bus.res_valid = 1'b0; bus.res_count = '0; bus.best_ready = 1'b0;
        cycle(); cycle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_res_ready", 32'(bus.res_ready), 32'd0);
        chk("rst_best_valid", 32'(bus.best_valid), 32'd0);
        rst = 1'b0;
        cycle();

        // Basic sweep, everything ready.
        start_sweep();
        finish_sweep(200);
        check_mode0_recs();

        // req_ready stall mid-sweep.
        start_sweep();
        cycle(); cycle();
        rr_en = 1'b0; res_en = 1'b0;
        cycle();
        hold_obs = int'(bus.req_obs_addr);
        hold_nav = int'(bus.req_nav_addr);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_req_valid", 32'(bus.req_valid), 32'd1);
            chk("stall_obs", 32'(bus.req_obs_addr), 32'(hold_obs));
            chk("stall_nav", 32'(bus.req_nav_addr), 32'(hold_nav));
        end
        rr_en = 1'b1; res_en = 1'b1;
        finish_sweep(200);
        check_mode0_recs();

        // Results withheld: credit limit caps issue.
        res_en = 1'b0;
        start_sweep();
        for (int i = 0; i < 20; i++) cycle();
        chk("credit_issued", 32'(issued), 32'(MAX_OUT));
        chk("credit_req_valid", 32'(bus.req_valid), 32'd0);
        res_en = 1'b1;
        finish_sweep(200);
        check_mode0_recs();

        // Record back-pressure on obs1's final result.
        br_en = 1'b0;
        start_sweep();
        for (int i = 0; i < 30; i++) cycle();
        chk("bp_stall_seen", 32'(stall_seen), 32'd1);
        chk("bp_best_valid", 32'(bus.best_valid), 32'd1);
        chk("bp_best_obs", 32'(bus.best_obs), 32'd0);
        chk("bp_best_nav", 32'(bus.best_nav), 32'd1);
        chk("bp_no_recs", 32'(rec_obs.size()), 32'd0);
        chk("bp_pending_results", 32'(q_obs.size()), 32'd1);
        br_en = 1'b1;
        finish_sweep(200);
        check_mode0_recs();

        // All-equal counts: tie keeps nav 0, below hit threshold.
        mode = 1;
        start_sweep();
        finish_sweep(200);
        check_rec(0, 0, 0, 3, 0);
        check_rec(1, 1, 0, 3, 0);
        mode = 0;

        // Reset mid-ISSUE with 3 outstanding.
        res_en = 1'b0;
        start_sweep();
        n = 0;
        while (issued < 3 && n < 20) begin
            cycle();
            n++;
        end
        chk("rst_mid_issued", 32'(issued), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        bus.req_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_valid", 32'(bus.req_valid), 32'd0);
        chk("abort_best_valid", 32'(bus.best_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        res_en = 1'b1;
        start_sweep();
        finish_sweep(200);
        check_mode0_recs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
